// File: rtl/muldiv_if.sv
// Issue/result bundle between the control unit and the HI/LO multiply-divide engine.
interface muldiv_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            mthi;
    logic            mtlo;
    logic [XLEN-1:0] mt_data;
    logic            read_hi;
    logic            read_lo;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, op_a, op_b, mthi, mtlo, mt_data, read_hi, read_lo,
        input  busy, stall, done, hi, lo
    );

    modport slave (
        input  start, op, op_a, op_b, mthi, mtlo, mt_data, read_hi, read_lo,
        output busy, stall, done, hi, lo
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO: one bit per cycle, fixed
// 34-edge latency, with a stall towards the issuing instruction stream.
module muldiv_sequencer #(
    parameter int unsigned XLEN = 32
) (
    input  logic      clk,
    input  logic      reset,
    muldiv_if.slave   bus
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   count;
    logic [AW-1:0]   acc;
    logic [XLEN-1:0] opnd;
    logic            sign_a;
    logic            sign_b;
    logic [1:0]      op_r;
    logic            divzero;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    logic            in_signed;
    logic            in_div;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN:0]   mul_sum;
    logic [AW-1:0]   mul_next;
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   rem_diff;
    logic            q_bit;
    logic [AW-1:0]   div_next;
    logic [AW-1:0]   prod;
    logic [XLEN-1:0] quot;
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] res_hi;
    logic [XLEN-1:0] res_lo;

    // Operand magnitudes at issue: signed ops use two's-complement |x|.
    always_comb begin
        in_signed = ~bus.op[0];
        in_div    = bus.op[1];
        a_mag     = (in_signed && bus.op_a[XLEN-1]) ? XLEN'(-bus.op_a) : bus.op_a;
        b_mag     = (in_signed && bus.op_b[XLEN-1]) ? XLEN'(-bus.op_b) : bus.op_b;
    end

    // One iteration step. acc = {upper, lower}; mult shifts right, divide shifts left.
    always_comb begin
        mul_sum  = {1'b0, acc[AW-1:XLEN]} + (acc[0] ? {1'b0, opnd} : (XLEN+1)'(0));
        mul_next = {mul_sum, acc[XLEN-1:1]};
        rem_sh   = acc[AW-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opnd};
        q_bit    = ~rem_diff[XLEN];
        div_next = {(q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc[XLEN-2:0], q_bit};
    end

    // Sign fix-up; unsigned ops latch both signs as 0 so no correction applies.
    // A zero divisor leaves |dividend| as remainder, so the sign fix restores op_a.
    always_comb begin
        prod   = (sign_a ^ sign_b) ? AW'(-acc) : acc;
        quot   = (sign_a ^ sign_b) ? XLEN'(-acc[XLEN-1:0]) : acc[XLEN-1:0];
        rem    = sign_a ? XLEN'(-acc[AW-1:XLEN]) : acc[AW-1:XLEN];
        res_hi = prod[AW-1:XLEN];
        res_lo = prod[XLEN-1:0];
        if (op_r[1]) begin
            res_hi = rem;
            res_lo = divzero ? {XLEN{1'b1}} : quot;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            acc     <= '0;
            opnd    <= '0;
            sign_a  <= 1'b0;
            sign_b  <= 1'b0;
            op_r    <= 2'b00;
            divzero <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        // Issue wins over a same-cycle MTHI/MTLO.
                        sign_a  <= in_signed & bus.op_a[XLEN-1];
                        sign_b  <= in_signed & bus.op_b[XLEN-1];
                        op_r    <= bus.op;
                        divzero <= in_div & (bus.op_b == '0);
                        opnd    <= in_div ? b_mag : a_mag;
                        acc     <= {{XLEN{1'b0}}, (in_div ? a_mag : b_mag)};
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        if (bus.mthi) hi <= bus.mt_data;
                        if (bus.mtlo) lo <= bus.mt_data;
                    end
                end
                RUN: begin
                    acc   <= op_r[1] ? div_next : mul_next;
                    count <= count + CW'(1);
                    if (count == CW'(XLEN - 1)) state <= FIX;
                end
                FIX: begin
                    hi    <= res_hi;
                    lo    <= res_lo;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy  = busy;
    assign bus.done  = done;
    assign bus.hi    = hi;
    assign bus.lo    = lo;
    assign bus.stall = busy & (bus.start | bus.read_hi | bus.read_lo | bus.mthi | bus.mtlo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, latency, stall and async reset.
module tb_muldiv_sequencer;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_fail;
    int   edges;
    logic [31:0] prev_hi;

    muldiv_if #(.XLEN(32)) bus ();

    muldiv_sequencer #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for done; edges counts edges after the issue edge.
    task automatic wait_done(input string tag);
        edges = 0;
        while (bus.done !== 1'b1 && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (edges == 16) chk({tag, "_hi_hold"}, 64'(bus.hi), 64'(prev_hi));
        end
        chk({tag, "_latency"}, 64'(edges), 64'd33);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        @(negedge clk);
        prev_hi    = bus.hi;
        bus.start  = 1'b1;
        bus.op     = o;
        bus.op_a   = a;
        bus.op_b   = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
        wait_done(tag);
        chk({tag, "_hi"}, 64'(bus.hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(bus.lo), 64'(elo));
        chk({tag, "_idle"}, 64'(bus.busy), 64'd0);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        bus.start = 1'b0; bus.op = 2'b00; bus.op_a = '0; bus.op_b = '0;
        bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.mt_data = '0;
        bus.read_hi = 1'b0; bus.read_lo = 1'b0;
        #12;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_hi", 64'(bus.hi), 64'd0);
        chk("rst_lo", 64'(bus.lo), 64'd0);
        chk("rst_stall", 64'(bus.stall), 64'd0);
        @(negedge clk); reset = 1'b0;

        run_op("mult_7_m3",   2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB);
        run_op("multu_max",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_m1_m1",  2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001);
        run_op("div_m7_2",    2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_100_7",  2'b11, 32'd100,      32'd7,        32'd2,        32'd14);
        run_op("div_min_m1",  2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        run_op("divu_100_0",  2'b11, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF);
        run_op("div_m100_0",  2'b10, 32'hFFFFFF9C, 32'd0,        32'hFFFFFF9C, 32'hFFFFFFFF);
        run_op("div_7_m2",    2'b10, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD);

        // Same-cycle MTHI with start: the write must be dropped.
        bus.mthi = 1'b1; bus.mt_data = 32'hDEAD;
        run_op("start_vs_mthi", 2'b01, 32'd2, 32'd3, 32'd0, 32'd6);

        // MFHI waiting on an in-flight MULTU, plus a second start while busy.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'h10000; bus.op_b = 32'h10000;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.read_hi = 1'b1;
        edges = 0;
        chk("stall_first", 64'(bus.stall), 64'd1);
        while (edges < 40) begin
            @(posedge clk); #1;
            edges++;
            if (bus.done === 1'b1) break;
            chk("stall_hold", 64'(bus.stall), 64'd1);
            if (edges == 5) begin
                bus.start = 1'b1; bus.op = 2'b01; bus.op_a = 32'd3; bus.op_b = 32'd5;
            end
        end
        chk("stall_latency", 64'(edges), 64'd33);
        chk("stall_drop", 64'(bus.stall), 64'd0);
        chk("stall_hi", 64'(bus.hi), 64'd1);
        chk("stall_lo", 64'(bus.lo), 64'd0);
        bus.read_hi = 1'b0;
        prev_hi = bus.hi;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("second_start_busy", 64'(bus.busy), 64'd1);
        wait_done("second");
        chk("second_hi", 64'(bus.hi), 64'd0);
        chk("second_lo", 64'(bus.lo), 64'd15);

        // Load known HI/LO, then reset asynchronously in the middle of a DIV.
        @(negedge clk);
        bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.mt_data = 32'h5A5A;
        @(posedge clk); #1;
        bus.mthi = 1'b0; bus.mtlo = 1'b0;
        chk("mt_both_hi", 64'(bus.hi), 64'h5A5A);
        chk("mt_both_lo", 64'(bus.lo), 64'h5A5A);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.op_a = 32'd1000; bus.op_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_hi", 64'(bus.hi), 64'd0);
        chk("arst_lo", 64'(bus.lo), 64'd0);
        chk("arst_done", 64'(bus.done), 64'd0);
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        bus.mtlo = 1'b1; bus.mt_data = 32'h1234;
        #1;
        chk("mtlo_stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.mtlo = 1'b0;
        chk("mtlo_lo", 64'(bus.lo), 64'h1234);
        chk("mtlo_hi", 64'(bus.hi), 64'd0);
        chk("mtlo_stall_after", 64'(bus.stall), 64'd0);
        chk("mtlo_no_done", 64'(bus.done), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
